// File: rtl/act_row_feeder.sv
// act_row_feeder: steers one tagged activation stream into N_ROW per-row FWFT FIFOs.
// Latency: a beat pushed into an empty row FIFO is presented on that row one cycle later.
// Backpressure: in_rdy drops while the addressed row is full. A pop does not free the slot
//   until the next cycle. Illegal row tags are always consumed and then dropped.
//
// Ports:
//   clk_l, rst         single clock, synchronous active-high reset
//   in_data/in_row     activation beat {word1, word0} and its destination row
//   in_vld/in_rdy      upstream handshake; in_rdy does not depend on in_vld
//   act_data_in[_vld]  per-row head word pair and non-empty flag, packed by row
//   act_data_in_req    per-row consumer ready; pops when vld && req
//   fill_lvl           per-row occupancy, packed by row
//   err_row            sticky flag: a beat with an out-of-range row tag was seen
//   idle               all FIFOs are empty and no beat is offered
//   in_bcast           (ACT_FEED_BCAST_EN only) push the beat into every row
module act_row_feeder #(
  parameter int N_ROW      = 7,
  parameter int WID_ACT    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int WID_ROW    = $clog2(N_ROW),
  parameter int WID_CNT    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                           clk_l,
  input  logic                           rst,
  input  logic [2*WID_ACT-1:0]           in_data,
  input  logic [WID_ROW-1:0]             in_row,
  input  logic                           in_vld,
`ifdef ACT_FEED_BCAST_EN
  input  logic                           in_bcast,
`endif
  output logic                           in_rdy,
  output logic [2*WID_ACT*N_ROW-1:0]     act_data_in,
  output logic [N_ROW-1:0]               act_data_in_vld,
  input  logic [N_ROW-1:0]               act_data_in_req,
  output logic [WID_CNT*N_ROW-1:0]       fill_lvl,
  output logic                           err_row,
  output logic                           idle
);

  localparam int WID_DAT = 2 * WID_ACT;
  localparam int WID_PTR = WID_CNT - 1;
  // One extra bit so the compare also works when N_ROW is a power of two.
  localparam logic [WID_ROW:0]   ROW_LIM = (WID_ROW + 1)'(N_ROW);
  localparam logic [WID_CNT-1:0] DEPTH_C = WID_CNT'(FIFO_DEPTH);

  logic [N_ROW-1:0] row_full;
  logic [N_ROW-1:0] row_busy;
  logic [N_ROW-1:0] push_row;
  logic             sel_full;
  logic             row_legal;
  logic             bcast;
  logic             rdy_raw;
  logic             accept;
  logic             err_q;

  // ---------------------------------------------------------------------------
  // Ingress steering
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_full  = 1'b0;
    for (int r = 0; r < N_ROW; r++) begin
      if (in_row == WID_ROW'(r)) sel_full = row_full[r];
    end
    row_legal = ({1'b0, in_row} < ROW_LIM);
    // Illegal tags are always ready so a bad beat cannot wedge the stream.
    rdy_raw   = row_legal ? ~sel_full : 1'b1;
    bcast     = 1'b0;
`ifdef ACT_FEED_BCAST_EN
    bcast     = in_bcast;
    if (in_bcast) rdy_raw = ~|row_full;
`endif
  end

  assign in_rdy = ~rst & rdy_raw;
  assign accept = in_vld & in_rdy;

  always_comb begin
    push_row = '0;
    for (int r = 0; r < N_ROW; r++) begin
      push_row[r] = accept & (bcast | (row_legal & (in_row == WID_ROW'(r))));
    end
  end

  always_ff @(posedge clk_l) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && !bcast && !row_legal) begin
      err_q <= 1'b1;
    end
  end

  assign err_row = err_q & ~rst;
  assign idle    = rst | (~|row_busy & ~in_vld);

  // ---------------------------------------------------------------------------
  // Per-row FWFT FIFOs. The head is held in its own register so the output
  // keeps its last value once the FIFO drains, and reads as zero after reset.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    logic [WID_DAT-1:0] mem [FIFO_DEPTH];
    logic [WID_PTR-1:0] rd_ptr;
    logic [WID_PTR-1:0] wr_ptr;
    logic [WID_PTR-1:0] rd_ptr_nxt;
    logic [WID_CNT-1:0] cnt;
    logic [WID_DAT-1:0] head;
    logic               pop;

    assign pop        = act_data_in_vld[r] & act_data_in_req[r];
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk_l) begin
      if (push_row[r]) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk_l) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        head   <= '0;
      end else begin
        if (push_row[r]) wr_ptr <= wr_ptr + 1'b1;
        if (pop)         rd_ptr <= rd_ptr_nxt;

        case ({push_row[r], pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase

        // The next head comes from the array when a second entry is already
        // stored; otherwise the incoming beat goes straight into the head.
        if (pop) begin
          if (cnt > WID_CNT'(1))  head <= mem[rd_ptr_nxt];
          else if (push_row[r])   head <= in_data;
        end else if (push_row[r] && cnt == '0) begin
          head <= in_data;
        end
      end
    end

    assign row_full[r]                           = (cnt == DEPTH_C);
    assign row_busy[r]                           = (cnt != '0);
    assign act_data_in_vld[r]                    = ~rst & row_busy[r];
    assign act_data_in[r*WID_DAT +: WID_DAT]     = rst ? '0 : head;
    assign fill_lvl[r*WID_CNT +: WID_CNT]        = cnt;
  end

endmodule
